// File: rtl/id_stage_pipelined_pkg.sv
// rtl/id_stage_pipelined_pkg.sv - opcode/funct IDs, ALU codes and shared constants for the ID stage
package id_stage_pipelined_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam int ALU_OP_WIDTH  = 4;
    localparam int ALU_CAT_WIDTH = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_ADDU, ALU_SUBU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [ALU_CAT_WIDTH-1:0] {
        CAT_NOP, CAT_LOGIC, CAT_ARITH, CAT_SHIFT, CAT_MEMORY
    } alu_cat_e;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

endpackage

// File: rtl/id_operand_select.sv
// rtl/id_operand_select.sv - one read port: immediate/forward/regfile mux and its RAW hazard term
module id_operand_select
    import id_stage_pipelined_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int FORWARDING_ENABLE = 1
) (
    input  logic                  read_enable,
    input  logic [4:0]            read_addr,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  logic [DATA_WIDTH-1:0] read_result,
    input  logic                  ex_write_enable,
    input  logic [4:0]            ex_write_addr,
    input  logic [DATA_WIDTH-1:0] ex_write_data,
    input  logic                  ex_is_load,
    input  logic                  mem_write_enable,
    input  logic [4:0]            mem_write_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  hazard
);

    logic ex_match;
    logic mem_match;

    // r0 is hardwired, so a writer targeting it never matches a reader
    assign ex_match  = ex_write_enable  && (ex_write_addr  == read_addr) && (read_addr != NOP_REG_ADDR);
    assign mem_match = mem_write_enable && (mem_write_addr == read_addr) && (read_addr != NOP_REG_ADDR);

    always_comb begin
        operand = read_result;
        if (read_enable == DISABLE) begin
            operand = immediate;
        end else if (read_addr == NOP_REG_ADDR) begin
            operand = '0;
        end else if ((FORWARDING_ENABLE != 0) && ex_match) begin
            operand = ex_write_data;
        end else if ((FORWARDING_ENABLE != 0) && mem_match) begin
            operand = mem_write_data;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (read_enable == ENABLE) begin
            if (FORWARDING_ENABLE != 0) begin
                hazard = ex_match && ex_is_load;
            end else begin
                hazard = ex_match || mem_match;
            end
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - MIPS decode stage with forwarding, load-use stall and ID/EX register
module id_stage_pipelined
    import id_stage_pipelined_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int FORWARDING_ENABLE = 1,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  program_counter,
    input  logic [31:0]                  instruction,
    input  logic                         instruction_valid,
    input  logic                         ex_write_enable,
    input  logic [4:0]                   ex_write_addr,
    input  logic [DATA_WIDTH-1:0]        ex_write_data,
    input  logic                         ex_is_load,
    input  logic                         mem_write_enable,
    input  logic [4:0]                   mem_write_addr,
    input  logic [DATA_WIDTH-1:0]        mem_write_data,
    input  logic [DATA_WIDTH-1:0]        read_result1,
    input  logic [DATA_WIDTH-1:0]        read_result2,
    output logic                         read_enable1,
    output logic                         read_enable2,
    output logic [4:0]                   read_addr1,
    output logic [4:0]                   read_addr2,
    input  logic                         stall_in,
    input  logic                         flush,
    output logic                         stall_request,
    output logic                         out_valid,
    output logic [31:0]                  out_program_counter,
    output logic [ALU_OP_WIDTH-1:0]      out_alu_operator,
    output logic [ALU_CAT_WIDTH-1:0]     out_alu_category,
    output logic [DATA_WIDTH-1:0]        out_operand1,
    output logic [DATA_WIDTH-1:0]        out_operand2,
    output logic                         out_write_enable,
    output logic [4:0]                   out_write_addr,
    output logic                         out_is_load,
    output logic                         out_invalid_instruction,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm16  = instruction[15:0];

    logic [DATA_WIDTH-1:0] imm_zext;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_lui;
    logic [DATA_WIDTH-1:0] shamt_ext;

    assign imm_zext  = DATA_WIDTH'(imm16);
    assign imm_sext  = DATA_WIDTH'($signed(imm16));
    assign imm_lui   = DATA_WIDTH'({imm16, 16'h0000});
    assign shamt_ext = DATA_WIDTH'(shamt);

    alu_op_e               dec_op;
    alu_cat_e              dec_cat;
    logic                  dec_re1;
    logic                  dec_re2;
    logic [DATA_WIDTH-1:0] dec_imm1;
    logic [DATA_WIDTH-1:0] dec_imm2;
    logic                  dec_we;
    logic [4:0]            dec_wa;
    logic                  dec_load;
    logic                  dec_invalid;

    always_comb begin
        dec_op      = ALU_NOP;
        dec_cat     = CAT_NOP;
        dec_re1     = DISABLE;
        dec_re2     = DISABLE;
        dec_imm1    = '0;
        dec_imm2    = '0;
        dec_we      = 1'b0;
        dec_wa      = NOP_REG_ADDR;
        dec_load    = 1'b0;
        dec_invalid = 1'b0;
        case (opcode)
            OP_ORI:   begin dec_op = ALU_OR;   dec_cat = CAT_LOGIC;  dec_re1 = ENABLE; dec_imm2 = imm_zext; dec_we = 1'b1; dec_wa = rt; end
            OP_ANDI:  begin dec_op = ALU_AND;  dec_cat = CAT_LOGIC;  dec_re1 = ENABLE; dec_imm2 = imm_zext; dec_we = 1'b1; dec_wa = rt; end
            OP_XORI:  begin dec_op = ALU_XOR;  dec_cat = CAT_LOGIC;  dec_re1 = ENABLE; dec_imm2 = imm_zext; dec_we = 1'b1; dec_wa = rt; end
            OP_ADDIU: begin dec_op = ALU_ADDU; dec_cat = CAT_ARITH;  dec_re1 = ENABLE; dec_imm2 = imm_sext; dec_we = 1'b1; dec_wa = rt; end
            OP_LW:    begin dec_op = ALU_ADDU; dec_cat = CAT_MEMORY; dec_re1 = ENABLE; dec_imm2 = imm_sext; dec_we = 1'b1; dec_wa = rt; dec_load = 1'b1; end
            // LUI is an OR of zero with the shifted immediate; rs is not read
            OP_LUI:   begin dec_op = ALU_OR;   dec_cat = CAT_LOGIC;  dec_imm2 = imm_lui; dec_we = 1'b1; dec_wa = rt; end
            OP_SPECIAL: begin
                dec_re1 = ENABLE;
                dec_re2 = ENABLE;
                dec_we  = 1'b1;
                dec_wa  = rd;
                case (funct)
                    FN_AND:  begin dec_op = ALU_AND;  dec_cat = CAT_LOGIC; end
                    FN_OR:   begin dec_op = ALU_OR;   dec_cat = CAT_LOGIC; end
                    FN_XOR:  begin dec_op = ALU_XOR;  dec_cat = CAT_LOGIC; end
                    FN_NOR:  begin dec_op = ALU_NOR;  dec_cat = CAT_LOGIC; end
                    FN_ADDU: begin dec_op = ALU_ADDU; dec_cat = CAT_ARITH; end
                    FN_SUBU: begin dec_op = ALU_SUBU; dec_cat = CAT_ARITH; end
                    FN_SLL:  begin dec_op = ALU_SLL;  dec_cat = CAT_SHIFT; dec_re1 = DISABLE; dec_imm1 = shamt_ext; end
                    FN_SRL:  begin dec_op = ALU_SRL;  dec_cat = CAT_SHIFT; dec_re1 = DISABLE; dec_imm1 = shamt_ext; end
                    FN_SRA:  begin dec_op = ALU_SRA;  dec_cat = CAT_SHIFT; dec_re1 = DISABLE; dec_imm1 = shamt_ext; end
                    default: begin
                        dec_re1     = DISABLE;
                        dec_re2     = DISABLE;
                        dec_we      = 1'b0;
                        dec_wa      = NOP_REG_ADDR;
                        dec_invalid = 1'b1;
                    end
                endcase
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    assign read_enable1 = dec_re1;
    assign read_enable2 = dec_re2;
    assign read_addr1   = rs;
    assign read_addr2   = rt;

    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic                  hazard1;
    logic                  hazard2;

    id_operand_select #(.DATA_WIDTH(DATA_WIDTH), .FORWARDING_ENABLE(FORWARDING_ENABLE)) u_port1 (
        .read_enable      (dec_re1),
        .read_addr        (rs),
        .immediate        (dec_imm1),
        .read_result      (read_result1),
        .ex_write_enable  (ex_write_enable),
        .ex_write_addr    (ex_write_addr),
        .ex_write_data    (ex_write_data),
        .ex_is_load       (ex_is_load),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .operand          (operand1),
        .hazard           (hazard1)
    );

    id_operand_select #(.DATA_WIDTH(DATA_WIDTH), .FORWARDING_ENABLE(FORWARDING_ENABLE)) u_port2 (
        .read_enable      (dec_re2),
        .read_addr        (rt),
        .immediate        (dec_imm2),
        .read_result      (read_result2),
        .ex_write_enable  (ex_write_enable),
        .ex_write_addr    (ex_write_addr),
        .ex_write_data    (ex_write_data),
        .ex_is_load       (ex_is_load),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .operand          (operand2),
        .hazard           (hazard2)
    );

    assign stall_request = instruction_valid && (hazard1 || hazard2) && !flush;

    // reset, flush and a locally requested stall all leave a clean bubble in ID/EX
    always_ff @(posedge clock) begin
        if (reset || flush || (!stall_in && stall_request)) begin
            out_valid               <= INVALID;
            out_program_counter     <= ZERO_WORD;
            out_alu_operator        <= ALU_NOP;
            out_alu_category        <= CAT_NOP;
            out_operand1            <= '0;
            out_operand2            <= '0;
            out_write_enable        <= 1'b0;
            out_write_addr          <= NOP_REG_ADDR;
            out_is_load             <= 1'b0;
            out_invalid_instruction <= 1'b0;
        end else if (!stall_in) begin
            out_valid               <= instruction_valid;
            out_program_counter     <= program_counter;
            out_alu_operator        <= dec_op;
            out_alu_category        <= dec_cat;
            out_operand1            <= operand1;
            out_operand2            <= operand2;
            out_write_enable        <= dec_we;
            out_write_addr          <= dec_wa;
            out_is_load             <= dec_load;
            out_invalid_instruction <= dec_invalid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!stall_in && stall_request && (stall_count != {STALL_COUNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + STALL_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - directed and random checks of id_stage_pipelined against a reference model
module tb_id_stage_pipelined;
    import id_stage_pipelined_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] program_counter, instruction;
    logic        instruction_valid;
    logic        ex_write_enable, ex_is_load;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_write_data;
    logic        mem_write_enable;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] read_result1, read_result2;
    logic        stall_in, flush;

    logic        re1_f, re2_f, sreq_f, ov_f, owe_f, old_f, oinv_f;
    logic [4:0]  ra1_f, ra2_f, owa_f;
    logic [31:0] opc_f, o1_f, o2_f;
    logic [3:0]  aop_f;
    logic [2:0]  acat_f;
    logic [15:0] cnt_f;

    logic        re1_n, re2_n, sreq_n, ov_n, owe_n, old_n, oinv_n;
    logic [4:0]  ra1_n, ra2_n, owa_n;
    logic [31:0] opc_n, o1_n, o2_n;
    logic [3:0]  aop_n;
    logic [2:0]  acat_n;
    logic [3:0]  cnt_n;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    id_stage_pipelined #(.DATA_WIDTH(32), .FORWARDING_ENABLE(1), .STALL_COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .program_counter(program_counter), .instruction(instruction),
        .instruction_valid(instruction_valid), .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .ex_is_load(ex_is_load), .mem_write_enable(mem_write_enable),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data), .read_result1(read_result1),
        .read_result2(read_result2), .read_enable1(re1_f), .read_enable2(re2_f), .read_addr1(ra1_f),
        .read_addr2(ra2_f), .stall_in(stall_in), .flush(flush), .stall_request(sreq_f), .out_valid(ov_f),
        .out_program_counter(opc_f), .out_alu_operator(aop_f), .out_alu_category(acat_f),
        .out_operand1(o1_f), .out_operand2(o2_f), .out_write_enable(owe_f), .out_write_addr(owa_f),
        .out_is_load(old_f), .out_invalid_instruction(oinv_f), .stall_count(cnt_f)
    );

    id_stage_pipelined #(.DATA_WIDTH(32), .FORWARDING_ENABLE(0), .STALL_COUNT_WIDTH(4)) dut_nf (
        .clock(clock), .reset(reset), .program_counter(program_counter), .instruction(instruction),
        .instruction_valid(instruction_valid), .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .ex_is_load(ex_is_load), .mem_write_enable(mem_write_enable),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data), .read_result1(read_result1),
        .read_result2(read_result2), .read_enable1(re1_n), .read_enable2(re2_n), .read_addr1(ra1_n),
        .read_addr2(ra2_n), .stall_in(stall_in), .flush(flush), .stall_request(sreq_n), .out_valid(ov_n),
        .out_program_counter(opc_n), .out_alu_operator(aop_n), .out_alu_category(acat_n),
        .out_operand1(o1_n), .out_operand2(o2_n), .out_write_enable(owe_n), .out_write_addr(owa_n),
        .out_is_load(old_n), .out_invalid_instruction(oinv_n), .stall_count(cnt_n)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  cat;
        logic        re1, re2;
        logic [4:0]  a1, a2;
        logic [31:0] imm1, imm2;
        logic        we;
        logic [4:0]  wa;
        logic        ld, inv;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [2:0]  cat;
        logic [31:0] op1, op2;
        logic        we;
        logic [4:0]  wa;
        logic        ld, inv;
    } idex_t;

    idex_t       exp_q [2];
    bit          full_q [2];
    int unsigned cnt_q [2];
    int unsigned cnt_max [2] = '{65535, 15};

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [15:0] imm;
        imm = ins[15:0];
        d = '0;
        d.a1 = ins[25:21];
        d.a2 = ins[20:16];
        d.we = 1'b1;
        d.wa = ins[20:16];
        case (ins[31:26])
            6'h0D: begin d.op = ALU_OR;   d.cat = CAT_LOGIC;  d.re1 = 1; d.imm2 = {16'h0, imm}; end
            6'h0C: begin d.op = ALU_AND;  d.cat = CAT_LOGIC;  d.re1 = 1; d.imm2 = {16'h0, imm}; end
            6'h0E: begin d.op = ALU_XOR;  d.cat = CAT_LOGIC;  d.re1 = 1; d.imm2 = {16'h0, imm}; end
            6'h09: begin d.op = ALU_ADDU; d.cat = CAT_ARITH;  d.re1 = 1; d.imm2 = {{16{imm[15]}}, imm}; end
            6'h23: begin d.op = ALU_ADDU; d.cat = CAT_MEMORY; d.re1 = 1; d.imm2 = {{16{imm[15]}}, imm}; d.ld = 1; end
            6'h0F: begin d.op = ALU_OR;   d.cat = CAT_LOGIC;  d.imm2 = {imm, 16'h0}; end
            6'h00: begin
                d.wa = ins[15:11];
                d.re1 = 1; d.re2 = 1;
                case (ins[5:0])
                    6'h24: begin d.op = ALU_AND;  d.cat = CAT_LOGIC; end
                    6'h25: begin d.op = ALU_OR;   d.cat = CAT_LOGIC; end
                    6'h26: begin d.op = ALU_XOR;  d.cat = CAT_LOGIC; end
                    6'h27: begin d.op = ALU_NOR;  d.cat = CAT_LOGIC; end
                    6'h21: begin d.op = ALU_ADDU; d.cat = CAT_ARITH; end
                    6'h23: begin d.op = ALU_SUBU; d.cat = CAT_ARITH; end
                    6'h00, 6'h02, 6'h03: begin
                        d.op  = (ins[1:0] == 2'd0) ? ALU_SLL : (ins[1:0] == 2'd2) ? ALU_SRL : ALU_SRA;
                        d.cat = CAT_SHIFT; d.re1 = 0; d.imm1 = {27'h0, ins[10:6]};
                    end
                    default: begin d.re1 = 0; d.re2 = 0; d.we = 0; d.wa = 0; d.inv = 1; end
                endcase
            end
            default: begin d.we = 0; d.wa = 0; d.inv = 1; end
        endcase
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input bit fwd, input logic re, input logic [4:0] a,
                                                input logic [31:0] imm, input logic [31:0] rf);
        if (!re) return imm;
        if (a == 5'd0) return 32'h0;
        if (fwd && ex_write_enable && ex_write_addr == a) return ex_write_data;
        if (fwd && mem_write_enable && mem_write_addr == a) return mem_write_data;
        return rf;
    endfunction

    function automatic bit ref_hazard(input bit fwd, input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 0;
        if (fwd) return ex_is_load && ex_write_enable && ex_write_addr == a;
        return (ex_write_enable && ex_write_addr == a) || (mem_write_enable && mem_write_addr == a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic idex_t observed(input int k);
        if (k == 0) return '{ov_f, opc_f, aop_f, acat_f, o1_f, o2_f, owe_f, owa_f, old_f, oinv_f};
        return '{ov_n, opc_n, aop_n, acat_n, o1_n, o2_n, owe_n, owa_n, old_n, oinv_n};
    endfunction

    task automatic bubble(input int k);
        exp_q[k].valid = 0; exp_q[k].we = 0; exp_q[k].op = ALU_NOP; exp_q[k].cat = CAT_NOP;
        exp_q[k].ld = 0; exp_q[k].inv = 0; full_q[k] = 0;
    endtask

    task automatic cycle();
        dec_t  d;
        idex_t o;
        bit    sr [2];
        #1;
        d = ref_decode(instruction);
        for (int k = 0; k < 2; k++)
            sr[k] = instruction_valid && !flush &&
                    (ref_hazard(k == 0, d.re1, d.a1) || ref_hazard(k == 0, d.re2, d.a2));
        check("read_enable1", re1_f, d.re1);
        check("read_enable2", re2_f, d.re2);
        if (d.re1) check("read_addr1", ra1_f, d.a1);
        if (d.re2) check("read_addr2", ra2_f, d.a2);
        check("stall_request_fwd", sreq_f, sr[0]);
        check("stall_request_nofwd", sreq_n, sr[1]);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                exp_q[k] = '0; full_q[k] = 1; cnt_q[k] = 0;
            end else if (flush) begin
                bubble(k);
            end else if (!stall_in) begin
                if (sr[k]) begin
                    bubble(k);
                    if (cnt_q[k] < cnt_max[k]) cnt_q[k]++;
                end else begin
                    exp_q[k] = '{instruction_valid, program_counter, d.op, d.cat,
                                 ref_operand(k == 0, d.re1, d.a1, d.imm1, read_result1),
                                 ref_operand(k == 0, d.re2, d.a2, d.imm2, read_result2),
                                 d.we, d.wa, d.ld, d.inv};
                    full_q[k] = 1;
                end
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = observed(k);
            check($sformatf("out_valid[%0d]", k), o.valid, exp_q[k].valid);
            check($sformatf("out_write_enable[%0d]", k), o.we, exp_q[k].we);
            check($sformatf("out_alu_operator[%0d]", k), o.op, exp_q[k].op);
            check($sformatf("out_alu_category[%0d]", k), o.cat, exp_q[k].cat);
            check($sformatf("out_is_load[%0d]", k), o.ld, exp_q[k].ld);
            check($sformatf("out_invalid[%0d]", k), o.inv, exp_q[k].inv);
            check($sformatf("stall_count[%0d]", k), (k == 0) ? 64'(cnt_f) : 64'(cnt_n), 64'(cnt_q[k]));
            if (full_q[k]) begin
                check($sformatf("out_pc[%0d]", k), o.pc, exp_q[k].pc);
                check($sformatf("out_operand1[%0d]", k), o.op1, exp_q[k].op1);
                check($sformatf("out_operand2[%0d]", k), o.op2, exp_q[k].op2);
                check($sformatf("out_write_addr[%0d]", k), o.wa, exp_q[k].wa);
            end
        end
    endtask

    task automatic idle();
        reset = 0; flush = 0; stall_in = 0; instruction_valid = 1;
        ex_write_enable = 0; ex_is_load = 0; ex_write_addr = 0; ex_write_data = $urandom;
        mem_write_enable = 0; mem_write_addr = 0; mem_write_data = $urandom;
        read_result1 = $urandom; read_result2 = $urandom;
        program_counter = program_counter + 32'd4;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    logic [5:0] op_pool [8] = '{6'h0D, 6'h0C, 6'h0E, 6'h09, 6'h23, 6'h0F, 6'h00, 6'h3F};
    logic [5:0] fn_pool [10] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h00, 6'h02, 6'h03, 6'h3A};

    initial begin
        program_counter = 32'h0000_1000;
        idle();
        reset = 1;
        instruction = itype(6'h0D, 5'd0, 5'd1, 16'h8000);
        cycle();
        cycle();
        check("reset_valid", ov_f, 1'b0);
        check("reset_count", cnt_f, 16'h0);

        idle();
        instruction = itype(6'h0D, 5'd0, 5'd1, 16'h8000);
        cycle();
        check("ori_op1", o1_f, 32'h0);
        check("ori_op2", o2_f, 32'h0000_8000);
        check("ori_wa", owa_f, 5'd1);
        check("ori_valid", ov_f, 1'b1);

        idle();
        instruction = itype(6'h09, 5'd0, 5'd2, 16'h8000);
        cycle();
        check("addiu_op2", o2_f, 32'hFFFF_8000);

        idle();
        ex_write_enable = 1; ex_write_addr = 3; ex_write_data = 32'h11;
        mem_write_enable = 1; mem_write_addr = 3; mem_write_data = 32'h22;
        read_result1 = 32'h33; read_result2 = 32'h33;
        instruction = rtype(5'd3, 5'd3, 5'd4, 5'd0, 6'h25);
        cycle();
        check("fwd_ex_op1", o1_f, 32'h11);
        check("fwd_ex_op2", o2_f, 32'h11);
        ex_write_enable = 0;
        cycle();
        check("fwd_mem_op1", o1_f, 32'h22);
        ex_write_enable = 1; ex_write_addr = 0; mem_write_addr = 0;
        instruction = rtype(5'd0, 5'd0, 5'd4, 5'd0, 6'h25);
        cycle();
        check("fwd_r0_op1", o1_f, 32'h0);

        idle();
        ex_write_enable = 1; ex_is_load = 1; ex_write_addr = 5;
        instruction = rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h21);
        #1 check("load_use_stall", sreq_f, 1'b1);
        cycle();
        check("load_use_bubble", ov_f, 1'b0);
        check("load_use_count", cnt_f, 16'd1);
        ex_write_enable = 0; ex_is_load = 0;
        mem_write_enable = 1; mem_write_addr = 5; mem_write_data = 32'hABC;
        #1 check("load_use_release", sreq_f, 1'b0);
        cycle();
        check("load_use_issue_op1", o1_f, 32'hABC);
        check("load_use_issue_valid", ov_f, 1'b1);

        idle();
        mem_write_enable = 1; mem_write_addr = 7;
        instruction = itype(6'h0D, 5'd7, 5'd8, 16'h0001);
        #1 check("nofwd_stall", sreq_n, 1'b1);
        cycle();
        mem_write_enable = 0;
        cycle();
        check("nofwd_issue_valid", ov_n, 1'b1);
        check("nofwd_issue_wa", owa_n, 5'd8);

        idle();
        instruction = itype(6'h0D, 5'd0, 5'd9, 16'h1234);
        cycle();
        flush = 1; stall_in = 1;
        cycle();
        check("flush_stall_bubble", ov_f, 1'b0);
        idle();
        instruction = itype(6'h0E, 5'd0, 5'd10, 16'h5678);
        cycle();
        stall_in = 1;
        instruction = itype(6'h0D, 5'd0, 5'd11, 16'h0F0F);
        cycle();
        check("stall_hold_op2", o2_f, 32'h5678);
        check("stall_hold_wa", owa_f, 5'd10);

        idle();
        instruction = 32'hFC00_0000;
        cycle();
        check("unknown_invalid", oinv_f, 1'b1);
        check("unknown_we", owe_f, 1'b0);

        idle();
        mem_write_enable = 1; mem_write_addr = 7;
        instruction = itype(6'h0D, 5'd7, 5'd8, 16'h0001);
        for (int i = 0; i < 20; i++) cycle();
        check("saturate_count", cnt_n, 4'hF);
        cycle();
        check("saturate_hold", cnt_n, 4'hF);

        for (int i = 0; i < 400; i++) begin
            idle();
            reset             = ($urandom_range(0, 63) == 0);
            flush             = ($urandom_range(0, 9) == 0);
            stall_in          = ($urandom_range(0, 7) == 0);
            instruction_valid = ($urandom_range(0, 7) != 0);
            ex_write_enable   = $urandom_range(0, 1);
            ex_is_load        = $urandom_range(0, 1);
            ex_write_addr     = 5'($urandom_range(0, 7));
            mem_write_enable  = $urandom_range(0, 1);
            mem_write_addr    = 5'($urandom_range(0, 7));
            instruction       = $urandom;
            instruction[31:26] = op_pool[$urandom_range(0, 7)];
            instruction[5:0]   = fn_pool[$urandom_range(0, 9)];
            instruction[25:21] = 5'($urandom_range(0, 7));
            instruction[20:16] = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
